// File: rtl/imem_loader_if.sv
// Host byte stream plus instruction-memory write port of the loader.
// slave = loader side, master = host/memory environment side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader: length word, N big-endian instructions, XOR
// checksum. Writes instruction memory and holds the core until a verified load.
//
// state | meaning
// IDLE  | after reset, waiting for start; core not held
// LEN   | collecting the 4-byte big-endian word count
// DATA  | collecting instruction bytes, one memory write per completed word
// CSUM  | waiting for the checksum byte
// DONE  | image verified, core released
// ERR   | bad length or checksum, core held
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] ONE_W = (ADDR_W+1)'(1);

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [23:0]       shreg;
  logic [ADDR_W:0]   len_words;
  logic [ADDR_W-1:0] word_idx;
  logic [7:0]        csum;

  logic              accept;
  logic [31:0]       word_next;
  logic              last_byte;
  logic              last_word;

  assign bus.in_ready = (state == LEN) || (state == DATA) || (state == CSUM);
  assign accept       = bus.in_valid && bus.in_ready;
  assign word_next    = {shreg, bus.in_data};
  assign last_byte    = (byte_cnt == 2'd3);
  assign last_word    = ({1'b0, word_idx} == (len_words - ONE_W));

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      byte_cnt       <= '0;
      shreg          <= '0;
      len_words      <= '0;
      word_idx       <= '0;
      csum           <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      cpu_hold       <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      words_loaded   <= '0;
    end else begin
      bus.imem_we <= 1'b0;

      // The write for a completed word issues even if start arrives with it.
      if (state == DATA && accept && last_byte) begin
        bus.imem_we    <= 1'b1;
        bus.imem_addr  <= word_idx;
        bus.imem_wdata <= word_next;
      end

      if (start) begin
        state        <= LEN;
        byte_cnt     <= '0;
        shreg        <= '0;
        len_words    <= '0;
        word_idx     <= '0;
        csum         <= '0;
        cpu_hold     <= 1'b1;
        done         <= 1'b0;
        err          <= 1'b0;
        words_loaded <= '0;
      end else begin
        case (state)
          LEN: begin
            if (accept) begin
              shreg    <= word_next[23:0];
              byte_cnt <= byte_cnt + 2'd1;
              if (last_byte) begin
                if (word_next == 32'd0 || word_next > 32'(DEPTH)) begin
                  state <= ERR;
                  err   <= 1'b1;
                end else begin
                  state     <= DATA;
                  len_words <= word_next[ADDR_W:0];
                  word_idx  <= '0;
                end
              end
            end
          end

          DATA: begin
            if (accept) begin
              shreg    <= word_next[23:0];
              csum     <= csum ^ bus.in_data;
              byte_cnt <= byte_cnt + 2'd1;
              if (last_byte) begin
                words_loaded <= words_loaded + ONE_W;
                if (last_word) begin
                  state <= CSUM;
                end else begin
                  word_idx <= word_idx + 1'b1;
                end
              end
            end
          end

          CSUM: begin
            if (accept) begin
              if (bus.in_data == csum) begin
                state    <= DONE;
                done     <= 1'b1;
                cpu_hold <= 1'b0;
              end else begin
                state <= ERR;
                err   <= 1'b1;
              end
            end
          end

          IDLE, DONE, ERR: begin
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad frames, illegal lengths, gaps,
// restart and reset mid-load, start coinciding with a write strobe.
module tb_imem_loader;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic cpu_hold, done, err;
  logic [ADDR_W:0] words_loaded;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];
  logic [31:0]       mem_model [DEPTH];

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_wdata);
      mem_model[bus.imem_addr] = bus.imem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget;
    bit rdy;
    budget = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        tick(1);
      end
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (!rdy && budget < 100);
    bus.in_valid = 1'b0;
    if (!rdy) chk("byte_accept_timeout", 32'(rdy), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gaps);
  endtask

  task automatic good_frame(input bit gaps, input logic [7:0] cs);
    send_word(32'd2, gaps);
    send_word(32'h1122_3344, gaps);
    send_word(32'hAABB_CCDD, gaps);
    send_byte(cs, gaps);
    tick(2);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_good(input string tag);
    chk({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      chk({tag, "_a0"}, 32'(wr_addr[0]), 32'd0);
      chk({tag, "_d0"}, wr_data[0], 32'h1122_3344);
      chk({tag, "_a1"}, 32'(wr_addr[1]), 32'd1);
      chk({tag, "_d1"}, wr_data[1], 32'hAABB_CCDD);
    end
    chk({tag, "_words"}, 32'(words_loaded), 32'd2);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 32'hDEAD_BEEF;
    tick(3);
    // reset overrides start and in_valid
    start = 1'b1;
    bus.in_valid = 1'b1;
    tick(1);
    start = 1'b0;
    bus.in_valid = 1'b0;
    reset = 1'b0;
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    chk("rst_rdy", 32'(bus.in_ready), 32'd0);
    chk("rst_we", 32'(bus.imem_we), 32'd0);

    // good load, in_valid held high
    clear_log();
    pulse_start();
    chk("start_rdy", 32'(bus.in_ready), 32'd1);
    chk("start_hold", 32'(cpu_hold), 32'd1);
    send_word(32'd2, 1'b0);
    send_word(32'h1122_3344, 1'b0);
    chk("wr0_we_next_cycle", 32'(bus.imem_we), 32'd1);
    chk("wr0_words_same_cycle", 32'(words_loaded), 32'd1);
    send_word(32'hAABB_CCDD, 1'b0);
    chk("in_csum_rdy", 32'(bus.in_ready), 32'd1);
    send_byte(8'h44, 1'b0);
    tick(2);
    check_good("good");

    // bad checksum
    clear_log();
    pulse_start();
    chk("restart_done_clr", 32'(done), 32'd0);
    good_frame(1'b0, 8'h45);
    chk("bad_nwr", 32'(wr_addr.size()), 32'd2);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_done", 32'(done), 32'd0);
    chk("bad_hold", 32'(cpu_hold), 32'd1);
    chk("bad_words", 32'(words_loaded), 32'd2);

    // len = 0
    clear_log();
    pulse_start();
    send_word(32'd0, 1'b0);
    chk("len0_err", 32'(err), 32'd1);
    chk("len0_rdy", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    tick(8);
    bus.in_valid = 1'b0;
    chk("len0_nwr", 32'(wr_addr.size()), 32'd0);
    chk("len0_err_hold", 32'(err), 32'd1);

    // len = 257
    pulse_start();
    send_word(32'h0000_0101, 1'b0);
    chk("len257_err", 32'(err), 32'd1);
    chk("len257_rdy", 32'(bus.in_ready), 32'd0);
    chk("len257_hold", 32'(cpu_hold), 32'd1);
    tick(2);
    chk("len257_nwr", 32'(wr_addr.size()), 32'd0);

    // len = DEPTH: word i = {i,i,i,i}, so the payload XOR is 0
    clear_log();
    pulse_start();
    send_word(32'(DEPTH), 1'b0);
    for (int i = 0; i < DEPTH; i++) send_word({4{8'(i)}}, 1'b0);
    send_byte(8'h00, 1'b0);
    tick(2);
    chk("full_nwr", 32'(wr_addr.size()), 32'(DEPTH));
    chk("full_words", 32'(words_loaded), 32'(DEPTH));
    chk("full_done", 32'(done), 32'd1);
    chk("full_last_data", mem_model[DEPTH-1], 32'hFFFF_FFFF);
    chk("full_mid_data", mem_model[8'h80], 32'h8080_8080);

    // random gaps in in_valid
    clear_log();
    pulse_start();
    good_frame(1'b1, 8'h44);
    check_good("gaps");

    // restart mid-load
    clear_log();
    pulse_start();
    send_word(32'd3, 1'b0);
    send_word(32'h5566_7788, 1'b0);
    send_byte(8'h99, 1'b0);
    send_byte(8'hAA, 1'b0);
    pulse_start();
    chk("rs_words_clr", 32'(words_loaded), 32'd0);
    good_frame(1'b0, 8'h44);
    chk("rs_nwr", 32'(wr_addr.size()), 32'd3);
    chk("rs_mem0", mem_model[0], 32'h1122_3344);
    chk("rs_mem1", mem_model[1], 32'hAABB_CCDD);
    chk("rs_words", 32'(words_loaded), 32'd2);
    chk("rs_done", 32'(done), 32'd1);

    // start in the same cycle as the pending write strobe
    clear_log();
    pulse_start();
    send_word(32'd1, 1'b0);
    send_word(32'hCAFE_F00D, 1'b0);
    chk("sw_we_pending", 32'(bus.imem_we), 32'd1);
    pulse_start();
    chk("sw_nwr", 32'(wr_addr.size()), 32'd1);
    chk("sw_mem0", mem_model[0], 32'hCAFE_F00D);
    chk("sw_words", 32'(words_loaded), 32'd0);
    chk("sw_rdy", 32'(bus.in_ready), 32'd1);
    chk("sw_we_gone", 32'(bus.imem_we), 32'd0);

    // reset mid-load after 6 payload bytes
    clear_log();
    pulse_start();
    send_word(32'd2, 1'b0);
    send_word(32'h1122_3344, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hCC;
    tick(1);
    reset = 1'b0;
    chk("mr_hold", 32'(cpu_hold), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_err", 32'(err), 32'd0);
    chk("mr_words", 32'(words_loaded), 32'd0);
    chk("mr_rdy", 32'(bus.in_ready), 32'd0);
    chk("mr_we", 32'(bus.imem_we), 32'd0);
    tick(8);
    bus.in_valid = 1'b0;
    chk("mr_nwr", 32'(wr_addr.size()), 32'd1);
    chk("mr_rdy_idle", 32'(bus.in_ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the instruction memory. Receives a framed byte stream from a host link (UART receiver or testbench), packs bytes into 32-bit instructions, and writes them into the instruction memory at word indices 0..N-1.
- Holds the processor core in reset while a load is in progress, then releases it on a verified load.
- Frame format: 4-byte word count N (MSB first), then N instructions of 4 bytes each (MSB first), then a 1-byte XOR checksum over the payload bytes only.

Parameters:
- DEPTH, 256, instruction memory entries; largest legal N.
- ADDR_W, 8, width of the word index; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins or restarts a load.
- in_data  input  8  incoming frame byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid && in_ready.
- imem_we  output  1  one-cycle write strobe to the instruction memory.
- imem_addr  output  ADDR_W  word index being written.
- imem_wdata  output  32  instruction word being written.
- cpu_hold  output  1  holds the core in reset.
- done  output  1  the last load completed with a matching checksum.
- err  output  1  the last load was rejected.
- words_loaded  output  ADDR_W+1  number of words written in the current or last load.

Behaviour:
- Reset (synchronous, active-high): state=IDLE. All outputs 0, including cpu_hold; words_loaded=0. Byte counter, length register and checksum accumulator are cleared. Memory contents are not touched. Reset overrides start and in_valid in the same cycle.
- States: IDLE, LEN, DATA, CSUM, DONE, ERR.
- in_ready: 1 only in LEN, DATA and CSUM, combinationally from the state. An in_valid byte in any other state is ignored.
- start (in any non-reset state, including mid-load): on the next cycle, state=LEN, cpu_hold=1, done=0, err=0, words_loaded=0, and the counters and checksum are cleared. A partially assembled word is discarded. Words already written stay in memory.
- LEN:
  - Shift in 4 accepted bytes as len[31:0], first byte into [31:24].
  - After the 4th byte: if len==0 or len>DEPTH, go to ERR; otherwise go to DATA with word index=0.
- DATA:
  - Shift in accepted bytes, first byte into [31:24]. XOR each accepted byte into the checksum.
  - On acceptance of a word's 4th byte, in the next cycle: imem_we=1 for exactly one cycle, imem_addr=word index, imem_wdata=assembled word. words_loaded increments in that same cycle.
  - Word index wraps only through a restart; it never exceeds len-1.
  - When the accepted 4th byte completes word len-1, go to CSUM. The write for that word still issues in the following cycle.
  - in_ready stays 1 during the write cycle; back-to-back bytes are legal.
- CSUM:
  - 1 accepted byte. If it equals the checksum accumulator, go to DONE; otherwise go to ERR.
- DONE: done=1, cpu_hold=0. The state holds until start.
- ERR: err=1, cpu_hold=1 (the core stays held on a bad image). The state holds until start.
- Gaps in in_valid (any length) only stall progress; no timeout.
- imem_we is never asserted outside the write cycle that follows a DATA word completion.
- A start pulse arriving in the same cycle as the pending write strobe: the strobe still issues, and the restart takes effect as above.

Test Plan:
- Good load: reset, start, then bytes 00 00 00 02, 11 22 33 44, AA BB CC DD, 44 with in_valid held high. Expect exactly two imem_we pulses, (addr 0, 0x11223344) then (addr 1, 0xAABBCCDD). Expect words_loaded=2, done=1, err=0, cpu_hold=0.
- Bad checksum: same frame with final byte 45. Expect both writes to occur, then err=1, done=0, cpu_hold=1.
- Illegal length: len=0, and separately len=0x00000101 (257). Expect ERR right after the 4th length byte, no imem_we, in_ready=0 afterwards.
- Backpressure and gaps: good-load frame with in_valid toggled randomly. Expect identical writes and final state to the good-load case, and no byte lost or duplicated.
- Restart mid-load: start, len=3, one full word, 2 bytes of the next word, then a start pulse, then the good-load frame. Expect addr 0 overwritten with 0x11223344, words_loaded=2, done=1.
- Reset mid-load: assert reset after 6 payload bytes. Next cycle expect all outputs 0, state IDLE, in_ready=0, and no further imem_we.
